// File: rtl/reset_seq_pkg.sv
// Shared types and widths for the staged reset sequencer.
package reset_seq_pkg;

  localparam int CNT_W   = 8;  // per-stage delay counter width
  localparam int STAGE_W = 4;  // stage index width (up to 16 stages)

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    DELAY = 3'd1,
    ACK   = 3'd2,
    RUN   = 3'd3,
    DOWN  = 3'd4,
    FAULT = 3'd5
  } state_t;

  // Saturating increment: the delay counter must stick at all-ones, never wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts on the
// second rising clock edge after reset_i falls.
module reset_sync (
  input  logic clock,
  input  logic reset_i,
  output logic rst_sync
);

  logic [1:0] sync_pipe;

  // Shift zeros in once the external reset is gone.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) sync_pipe <= 2'b11;
    else         sync_pipe <= {sync_pipe[0], 1'b0};
  end

  assign rst_sync = sync_pipe[1];

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer: releases N downstream resets in ascending order,
// waiting D cycles per stage and then for that stage's acknowledge; a restart
// request reasserts them in descending order and re-runs the release.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN -- bounds the acknowledge wait
// to T cycles and parks in FAULT (all resets asserted) on expiry.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 4,
  parameter int T = 16
) (
  input  logic               clock,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic [N-1:0]       ack_i,
  output logic [N-1:0]       rst_o,
  output logic [STAGE_W-1:0] stage_o,
  output logic               done_o,
  output logic               fault_o
);

  localparam logic [CNT_W-1:0]   D_LAST = CNT_W'(D - 1);
  localparam logic [STAGE_W-1:0] K_LAST = STAGE_W'(N - 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [STAGE_W-1:0] k, k_d;
  logic [N-1:0]       rst_q, rst_d;
  logic [N-1:0]       sel;
  logic               srst;
  logic               ack_k;
  logic               cnt_hit;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(T - 1);
  logic [15:0] tmr, tmr_d;
`endif

  reset_sync u_sync (
    .clock    (clock),
    .reset_i  (reset_i),
    .rst_sync (srst)
  );

  // One-hot select of the current stage; avoids indexing with a wider k.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) sel[i] = (k == STAGE_W'(i));
  end

  // Only the current stage's acknowledge matters; other bits are ignored.
  assign ack_k   = |(ack_i & sel);
  assign cnt_hit = (cnt == D_LAST);

  // Next-state, counter, stage index and reset-vector update.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    k_d     = k;
    rst_d   = rst_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    tmr_d   = tmr;
`endif
    case (state)
      HOLD: begin
        rst_d = '1;
        k_d   = '0;
        cnt_d = '0;
        if (!srst) state_d = DELAY;
      end
      DELAY: begin
        if (cnt_hit) begin
          rst_d   = rst_q & ~sel;
          cnt_d   = '0;
          state_d = ACK;
`ifdef RESET_SEQ_TIMEOUT_EN
          tmr_d   = '0;
`endif
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end
      ACK: begin
        if (ack_k) begin
          cnt_d = '0;
          if (k == K_LAST) begin
            state_d = RUN;
          end else begin
            k_d     = k + 1'b1;
            state_d = DELAY;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (tmr == TMO_LAST) begin
          state_d = FAULT;
          rst_d   = '1;
        end else begin
          tmr_d = tmr + 1'b1;
        end
`endif
      end
      RUN: begin
        if (req_i) begin
          state_d = DOWN;
          k_d     = K_LAST;
          cnt_d   = '0;
        end
      end
      DOWN: begin
        if (cnt_hit) begin
          rst_d = rst_q | sel;
          cnt_d = '0;
          if (k == '0) state_d = DELAY;
          else         k_d     = k - 1'b1;
        end else begin
          cnt_d = sat_inc(cnt);
        end
      end
`ifdef RESET_SEQ_TIMEOUT_EN
      FAULT: begin
        rst_d = '1;
        if (req_i) begin
          state_d = DELAY;
          k_d     = '0;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = HOLD;
    endcase
  end

  // Sequencer state; reset_i forces the safe state immediately.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state <= HOLD;
      cnt   <= '0;
      k     <= '0;
      rst_q <= '1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      k     <= k_d;
      rst_q <= rst_d;
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  // Acknowledge-wait timer, cleared on each entry into ACK.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) tmr <= '0;
    else         tmr <= tmr_d;
  end

  assign fault_o = (state == FAULT);
`else
  // Timeout parameter has no role in this build.
  logic unused_tmo;
  assign unused_tmo = ^16'(T);
  assign fault_o    = 1'b0;
`endif

  assign rst_o   = rst_q;
  assign done_o  = (state == RUN);
  assign stage_o = (state == DELAY || state == ACK || state == DOWN) ? k : '0;

endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq (N=4, D=4, default build without timeout).
module tb_reset_seq;

  logic       clock   = 1'b0;
  logic       reset_i = 1'b1;
  logic       req_i   = 1'b0;
  logic [3:0] ack_i   = 4'hF;
  logic [3:0] rst_o;
  logic [3:0] stage_o;
  logic       done_o;
  logic       fault_o;

  int tests = 0;
  int fails = 0;

  reset_seq #(.N(4), .D(4), .T(16)) dut (
    .clock   (clock),
    .reset_i (reset_i),
    .req_i   (req_i),
    .ack_i   (ack_i),
    .rst_o   (rst_o),
    .stage_o (stage_o),
    .done_o  (done_o),
    .fault_o (fault_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Release reset (call #1 after an edge) and follow the full power-up ramp.
  // rst_o[j] falls at edge 7+5j, done_o rises at edge 23.
  task automatic boot_check;
    logic [3:0] er;
    logic [3:0] es;
    reset_i = 1'b0;
    for (int e = 1; e <= 23; e++) begin
      tick();
      er = 4'hF;
      for (int j = 0; j < 4; j++) if (e >= 7 + 5 * j) er[j] = 1'b0;
      es = (e >= 3 && e <= 22) ? 4'((e - 3) / 5) : 4'd0;
      chk($sformatf("boot_rst_e%0d", e), 32'(rst_o), 32'(er));
      chk($sformatf("boot_stage_e%0d", e), 32'(stage_o), 32'(es));
      chk($sformatf("boot_done_e%0d", e), 32'(done_o), 32'(e >= 23));
      chk($sformatf("boot_fault_e%0d", e), 32'(fault_o), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] er;
    logic [3:0] es;

    // Reset state.
    tick();
    tick();
    chk("rst_rst_o", 32'(rst_o), 32'hF);
    chk("rst_stage", 32'(stage_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);

    // Power-up release with all acks high.
    boot_check();

    // Restart request pulse from RUN; req_i then held through DELAY/ACK.
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    chk("req_done", 32'(done_o), 32'd0);
    chk("req_stage", 32'(stage_o), 32'd3);
    chk("req_rst", 32'(rst_o), 32'd0);
    for (int m = 1; m <= 36; m++) begin
      req_i = (m >= 17 && m <= 35);
      tick();
      er = 4'h0;
      for (int j = 0; j < 4; j++)
        if (m >= 4 * (4 - j) && m < 20 + 5 * j) er[j] = 1'b1;
      if (m < 16)       es = 4'(3 - m / 4);
      else if (m < 36)  es = 4'((m - 16) / 5);
      else              es = 4'd0;
      chk($sformatf("down_rst_m%0d", m), 32'(rst_o), 32'(er));
      chk($sformatf("down_stage_m%0d", m), 32'(stage_o), 32'(es));
      chk($sformatf("down_done_m%0d", m), 32'(done_o), 32'(m >= 36));
    end
    req_i = 1'b0;

    // Asynchronous reset in RUN: outputs forced with no clock edge.
    reset_i = 1'b1;
    #1;
    chk("async_run_rst", 32'(rst_o), 32'hF);
    chk("async_run_done", 32'(done_o), 32'd0);
    tick();

    // Stall on ack_i[1]; stray ack_i[3] and dropped ack_i[0] are ignored.
    reset_i = 1'b0;
    ack_i   = 4'b0101;
    for (int e = 1; e <= 22; e++) begin
      tick();
      if (e == 14) ack_i[3] = 1'b1;
      if (e == 15) ack_i[3] = 1'b0;
      if (e == 17) ack_i[0] = 1'b0;
      if (e >= 12) begin
        chk($sformatf("stall_stage_e%0d", e), 32'(stage_o), 32'd1);
        chk($sformatf("stall_rst_e%0d", e), 32'(rst_o), 32'b1100);
        chk($sformatf("stall_done_e%0d", e), 32'(done_o), 32'd0);
      end
    end
    ack_i = 4'hF;
    tick();
    chk("resume_stage_e23", 32'(stage_o), 32'd2);
    chk("resume_rst_e23", 32'(rst_o), 32'b1100);
    tick();
    tick();
    chk("mid_stage_e25", 32'(stage_o), 32'd2);

    // Asynchronous reset while handling stage 2.
    reset_i = 1'b1;
    #1;
    chk("async_mid_rst", 32'(rst_o), 32'hF);
    chk("async_mid_stage", 32'(stage_o), 32'd0);
    chk("async_mid_done", 32'(done_o), 32'd0);
    tick();

    // Full sequence restarts from scratch.
    boot_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
